// File: rtl/ysyx_23060203_arb_pkg.sv
// Shared types and constants for the two-master AXI read arbiter.
// The build macro YSYX_23060203_ARB_RR_EN selects the tie rule in ysyx_23060203_arb_pick.
package ysyx_23060203_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      AR   = 2'd1,
      R    = 2'd2
   } arb_state_t;

   localparam logic ARB_IFU   = 1'b0;
   localparam logic ARB_LSU   = 1'b1;
   localparam int   ARB_LEN_W = 8;

   // Beat counter decrement that parks at zero instead of wrapping.
   function automatic logic [ARB_LEN_W-1:0] beat_dec(input logic [ARB_LEN_W-1:0] cnt);
      return (cnt == '0) ? '0 : cnt - ARB_LEN_W'(1);
   endfunction

endpackage

// File: rtl/ysyx_23060203_arb_pick.sv
// Combinational 2-way request picker; tie rule set by YSYX_23060203_ARB_RR_EN
// (defined: round-robin against last owner, undefined: LSU wins ties).
module ysyx_23060203_arb_pick
   import ysyx_23060203_arb_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       last_i,
   input  logic       mode_i,
   output logic       valid_o,
   output logic       idx_o
);

   logic tie_idx;

`ifdef YSYX_23060203_ARB_RR_EN
   assign tie_idx = ~last_i;
`else
   assign tie_idx = ARB_LSU;
`endif

   // mode_i opens the arbitration window; outside it nothing is granted.
   always_comb begin
      valid_o = mode_i & (|req_i);
      idx_o   = last_i;
      unique case (req_i)
         2'b01:   idx_o = ARB_IFU;
         2'b10:   idx_o = ARB_LSU;
         2'b11:   idx_o = tie_idx;
         default: idx_o = last_i;
      endcase
   end

endmodule

// File: rtl/ysyx_23060203_axi_read_arbiter.sv
// Two-to-one AXI read arbiter (IFU = master 0, LSU = master 1) onto one read slave.
// Grant taken on AR, held until the rlast beat; YSYX_23060203_ARB_RR_EN selects round-robin ties.
module ysyx_23060203_axi_read_arbiter
   import ysyx_23060203_arb_pkg::*;
#(
   parameter int ID_W   = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              ifu_arvalid_i,
   output logic              ifu_arready_o,
   input  logic [ADDR_W-1:0] ifu_araddr_i,
   input  logic [7:0]        ifu_arlen_i,
   input  logic [2:0]        ifu_arsize_i,
   input  logic [1:0]        ifu_arburst_i,
   input  logic [ID_W-1:0]   ifu_arid_i,
   output logic              ifu_rvalid_o,
   input  logic              ifu_rready_i,
   output logic [DATA_W-1:0] ifu_rdata_o,
   output logic [1:0]        ifu_rresp_o,
   output logic [ID_W-1:0]   ifu_rid_o,
   output logic              ifu_rlast_o,

   input  logic              lsu_arvalid_i,
   output logic              lsu_arready_o,
   input  logic [ADDR_W-1:0] lsu_araddr_i,
   input  logic [7:0]        lsu_arlen_i,
   input  logic [2:0]        lsu_arsize_i,
   input  logic [1:0]        lsu_arburst_i,
   input  logic [ID_W-1:0]   lsu_arid_i,
   output logic              lsu_rvalid_o,
   input  logic              lsu_rready_i,
   output logic [DATA_W-1:0] lsu_rdata_o,
   output logic [1:0]        lsu_rresp_o,
   output logic [ID_W-1:0]   lsu_rid_o,
   output logic              lsu_rlast_o,

   output logic              out_arvalid_o,
   input  logic              out_arready_i,
   output logic [ADDR_W-1:0] out_araddr_o,
   output logic [7:0]        out_arlen_o,
   output logic [2:0]        out_arsize_o,
   output logic [1:0]        out_arburst_o,
   output logic [ID_W-1:0]   out_arid_o,
   input  logic              out_rvalid_i,
   output logic              out_rready_o,
   input  logic [DATA_W-1:0] out_rdata_i,
   input  logic [1:0]        out_rresp_i,
   input  logic [ID_W-1:0]   out_rid_i,
   input  logic              out_rlast_i,

   output logic              busy_o,
   output logic              gnt_o
);

   arb_state_t             state_q, state_d;
   logic                   gnt_q, gnt_d;
   logic [ARB_LEN_W-1:0]   cnt_q, cnt_d;

   logic                   pick_valid;
   logic                   pick_idx;
   logic                   sel_arvalid;
   logic                   sel_rready;
   logic                   in_ar;
   logic                   in_r;
   logic                   ar_hs;
   logic                   r_hs;

   ysyx_23060203_arb_pick u_pick (
      .req_i   ({lsu_arvalid_i, ifu_arvalid_i}),
      .last_i  (gnt_q),
      .mode_i  (state_q == IDLE),
      .valid_o (pick_valid),
      .idx_o   (pick_idx)
   );

   assign in_ar = (state_q == AR);
   assign in_r  = (state_q == R);

   // AR channel: downstream request fields follow the owner; arvalid only escapes in AR.
   always_comb begin
      if (gnt_q == ARB_LSU) begin
         sel_arvalid   = lsu_arvalid_i;
         sel_rready    = lsu_rready_i;
         out_araddr_o  = lsu_araddr_i;
         out_arlen_o   = lsu_arlen_i;
         out_arsize_o  = lsu_arsize_i;
         out_arburst_o = lsu_arburst_i;
         out_arid_o    = lsu_arid_i;
      end else begin
         sel_arvalid   = ifu_arvalid_i;
         sel_rready    = ifu_rready_i;
         out_araddr_o  = ifu_araddr_i;
         out_arlen_o   = ifu_arlen_i;
         out_arsize_o  = ifu_arsize_i;
         out_arburst_o = ifu_arburst_i;
         out_arid_o    = ifu_arid_i;
      end
   end

   assign out_arvalid_o = in_ar & sel_arvalid;
   assign out_rready_o  = in_r & sel_rready;
   assign ar_hs         = out_arvalid_o & out_arready_i;
   assign r_hs          = in_r & out_rvalid_i & sel_rready;

   // Upstream returns: only the owner sees handshakes and R payload, the other reads zero.
   always_comb begin
      ifu_arready_o = 1'b0;
      ifu_rvalid_o  = 1'b0;
      ifu_rdata_o   = '0;
      ifu_rresp_o   = '0;
      ifu_rid_o     = '0;
      ifu_rlast_o   = 1'b0;
      lsu_arready_o = 1'b0;
      lsu_rvalid_o  = 1'b0;
      lsu_rdata_o   = '0;
      lsu_rresp_o   = '0;
      lsu_rid_o     = '0;
      lsu_rlast_o   = 1'b0;
      if (gnt_q == ARB_LSU) begin
         lsu_arready_o = in_ar & out_arready_i;
         lsu_rvalid_o  = in_r & out_rvalid_i;
         lsu_rdata_o   = out_rdata_i;
         lsu_rresp_o   = out_rresp_i;
         lsu_rid_o     = out_rid_i;
         lsu_rlast_o   = out_rlast_i;
      end else begin
         ifu_arready_o = in_ar & out_arready_i;
         ifu_rvalid_o  = in_r & out_rvalid_i;
         ifu_rdata_o   = out_rdata_i;
         ifu_rresp_o   = out_rresp_i;
         ifu_rid_o     = out_rid_i;
         ifu_rlast_o   = out_rlast_i;
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               gnt_d   = pick_idx;
               state_d = AR;
            end
         end
         AR: begin
            if (ar_hs) begin
               cnt_d   = out_arlen_o;
               state_d = R;
            end
         end
         R: begin
            if (r_hs) begin
               cnt_d = beat_dec(cnt_q);
               if (out_rlast_i) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= ARB_LSU;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy_o = (state_q != IDLE);
   assign gnt_o  = gnt_q;

`ifndef SYNTHESIS
   // rlast always wins; a beat count that disagrees points at a misbehaving slave.
   always @(posedge clk) begin
      if (!rst && r_hs) begin
         ARB_CHECK: assert (out_rlast_i == (cnt_q == '0))
            else $error("ARB_CHECK: rlast=%0b with beat count %0d", out_rlast_i, cnt_q);
      end
   end
`endif

endmodule

// File: doc/ysyx_23060203_axi_read_arbiter.md
# ysyx_23060203_axi_read_arbiter

Two-to-one AXI read-channel arbiter sharing one downstream read slave (the CLINT / device crossbar port) between the IFU and LSU read masters. One burst owns the slave at a time: grant is taken on AR, held through the R beat carrying `rlast`, then released. Sits between the core's read masters and the device/memory read path; write channels are not touched.

## Interface
- `ID_W`, default 4: AXI ID width, must match `axi_if` instances.
- `clk`  in  1: core clock, all state on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `ifu`  `axi_if.slave`  (AR/R fields): read requester 0, instruction fetch.
- `lsu`  `axi_if.slave`  (AR/R fields): read requester 1, load/store unit.
- `out`  `axi_if.master` (AR/R fields): shared downstream read port.
- `busy` out 1: high whenever state is not IDLE.
- `gnt`  out 1: index of current/last owner (0 = IFU, 1 = LSU).

## Operation
- States: IDLE, AR, R.
- IDLE: sample `ifu.arvalid`, `lsu.arvalid`. None -> stay. One -> grant it. Both -> tie rule (see Configuration). Grant latched into `gnt`, next state AR. No AR handshake occurs in IDLE.
- AR: `out.araddr/arlen/arsize/arburst/arid` and `out.arvalid` driven combinationally from granted master; granted master's `arready` = `out.arready`. On `out.arvalid && out.arready`: latch `arlen` into beat counter, go to R.
- R: `out.rdata/rresp/rid/rlast/rvalid` routed to granted master; `out.rready` = granted master's `rready`. Each R handshake decrements beat counter (8-bit, saturates at 0). On handshake with `rlast` -> IDLE.
- Non-granted master always sees `arready = 0`, `rvalid = 0`; other R fields don't-care (driven 0).
- In IDLE: `out.arvalid = 0`, `out.rready = 0`, both masters `arready = 0`, `rvalid = 0`.
- Masters must hold `arvalid` and AR fields stable until `arready` (AXI rule); arbiter does not buffer AR.
- `rlast` is authoritative. If `rlast` arrives with counter != 0, or counter hits 0 without `rlast`, arbiter still follows `rlast`; `ARB_CHECK` assertion fires in simulation (`ifndef SYNTHESIS`).
- `rresp` passed through unmodified; errors don't alter sequencing.

## Timing
- Reset: state IDLE, `gnt = 1` (so IFU wins first tie), beat counter 0, `busy = 0`, all handshake outputs 0.
- Reset mid-burst: immediate return to IDLE; in-flight burst abandoned, downstream must be reset together.
- Grant latency: `arvalid` seen in IDLE at cycle n -> `out.arvalid` at cycle n+1. Minimum one idle-cycle bubble between bursts (R -> IDLE -> AR).
- Zero added latency on AR/R paths once in AR/R (combinational mux).
- Single-beat read with always-ready slave: request cycle n, AR handshake n+1, R handshake n+2 earliest, next grant decision n+3.
- New request arriving during AR/R waits; no preemption.

## Configuration
- `YSYX_23060203_ARB_RR_EN` defined: round-robin tie break; on simultaneous requests the master not equal to `gnt` wins.
- Undefined: fixed priority, LSU always wins ties (IFU may starve under continuous LSU traffic; accepted).
- Single-requester behaviour identical in both builds.

## Structure
- Package `ysyx_23060203_arb_pkg`: `arb_state_t` enum (IDLE, AR, R), constants `ARB_IFU = 1'b0`, `ARB_LSU = 1'b1`, beat counter width `ARB_LEN_W = 8`.
- Sub-module `ysyx_23060203_arb_pick`: pure combinational 2-way picker (req[1:0], last, mode -> valid, idx); holds the macro-dependent tie rule.
- Top holds FSM, grant register, beat counter, channel muxes.

## Test plan
- Reset released, IFU alone reads 0x3000_0000 arlen=0, slave ready -> `out.araddr=0x3000_0000` at cycle 1, IFU gets one R beat rdata from slave, `rlast=1`, `busy` low cycle 3.
- IFU and LSU assert `arvalid` same cycle, RR build -> IFU granted first (`gnt=0`), LSU next after IFU's `rlast`; fixed build -> LSU first.
- LSU burst arlen=3 with slave `rvalid` toggling every other cycle, LSU `rready` stalled 2 cycles -> 4 beats delivered in order, grant held, IFU request pending throughout sees `arready=0`.
- Continuous back-to-back requests from both, 8 bursts, RR build -> strict alternation IFU/LSU/IFU...; exactly one IDLE bubble between bursts.
- Assert `rst` during R of a 4-beat burst after beat 2 -> state IDLE next edge, `busy=0`, `gnt=1`, no `rvalid` to either master.
- Slave returns `rresp=2'b10` on single beat -> routed unmodified to granted master, FSM returns IDLE normally.
